data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Data-memory slave for the single-cycle MIPS core. It is the responder end of the core's CEN/WEN/OEN/A/Data2Mem/ReadDataMem interface.
- Holds 128 x 32-bit words and performs synchronous writes.
- Returns read data after a parameterised latency through a read pipeline.
- Flags illegal strobe combinations and keeps saturating access counters plus a side-band debug read port for verification.

Parameters:
- READ_LAT, 1, cycles from read-capturing clock edge to ReadDataMem update; legal values 0, 1, 2 (0 = combinational read of the array).
- CNT_W, 16, width of the read and write access counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- CEN  input  1  chip enable, active-low; no access when high.
- WEN  input  1  write enable, active-low.
- OEN  input  1  output (read) enable, active-low.
- A  input  7  word address 0..127.
- Data2Mem  input  32  write data.
- ReadDataMem  output  32  read data.
- rd_valid  output  1  one-cycle pulse when ReadDataMem updates with a completed read.
- err_conflict  output  1  sticky flag: a write and a read were requested in the same cycle.
- rd_count  output  CNT_W  number of completed reads, saturating.
- wr_count  output  CNT_W  number of performed writes, saturating.
- dbg_addr  input  7  debug read address.
- dbg_data  output  32  combinational mem[dbg_addr]; has no side effects.

Behaviour:
- Reset is asynchronous while rst_n=0. On reset:
  - all 128 words are cleared to 0;
  - ReadDataMem=0, rd_valid=0, err_conflict=0, rd_count=0, wr_count=0;
  - read pipeline entries are invalidated. Reset mid-read discards the pending read; no rd_valid follows release of reset.
- Access decode, sampled at the rising edge:
  - WRITE = ~CEN & ~WEN.
  - READ = ~CEN & ~OEN & WEN.
  - CEN=1 means idle regardless of WEN/OEN.
  - ~CEN with WEN=1 and OEN=1 is idle; no error is raised.
- Write: mem[A] <= Data2Mem at the edge. The new value is visible to any read captured on a later edge and to dbg_data immediately after the edge.
- Conflict (~CEN & ~WEN & ~OEN):
  - the write is performed and the read is suppressed (no rd_valid is generated);
  - err_conflict sets and stays set until reset.
- Read with READ_LAT=0:
  - ReadDataMem = mem[A] combinationally whenever READ is true; otherwise it holds the last read value (a latch-free implementation keeps a registered copy of the last value).
  - rd_valid = READ, combinational.
  - rd_count increments at each edge where READ=1.
- Read with READ_LAT>=1:
  - at the edge where READ=1, mem[A] is captured into pipeline stage 1; the pipeline shifts one stage per cycle.
  - ReadDataMem and rd_valid update at the edge READ_LAT cycles after capture (READ_LAT=1: next edge; READ_LAT=2: one extra register stage).
  - Back-to-back reads are fully pipelined, one per cycle.
  - rd_valid is high for exactly one cycle per completed read.
  - ReadDataMem holds its last value between reads.
  - rd_count increments when a read completes.
- Read-after-write ordering:
  - a read captured on the edge after a write to the same address returns the new data;
  - with READ_LAT=0, a read in the same cycle as the write edge returns the pre-write data;
  - with READ_LAT>=1, a write to an address whose read is already in flight does not alter the in-flight data.
- Counters: wr_count increments once per performed write, including conflict writes. Both counters saturate at all-ones and do not wrap.
- Addresses: A is a full 7-bit index, so no out-of-range case exists. Address 127 followed by address 0 needs no special handling.

Test Plan:
- Reset then dbg sweep: pulse rst_n low asynchronously between edges. Required: all outputs 0 immediately, and dbg_data=0 for addresses 0..127.
- Write/read, READ_LAT=1: write 0xDEADBEEF to A=5, then read A=5. Required: ReadDataMem=0xDEADBEEF with rd_valid=1 exactly one cycle after the read edge; wr_count=1, rd_count=1.
- Pipelined reads, READ_LAT=2: preload A=0..3 with values 0x10..0x13, then read A=0,1,2,3 on consecutive cycles. Required: rd_valid high for 4 consecutive cycles starting 2 cycles after the first read, with data 0x10,0x11,0x12,0x13 in order.
- Conflict: drive CEN=0, WEN=0, OEN=0 with A=7 and Data2Mem=0x55. Required: mem[7]=0x55, no rd_valid, err_conflict=1 and still set 10 cycles later.
- Idle strobes: drive CEN=1 with WEN=0 and Data2Mem=0xFFFFFFFF at A=9. Required: mem[9] unchanged and wr_count unchanged.
- Reset mid-read plus saturation:
  - assert rst_n=0 one cycle after a READ_LAT=2 read. Required: no rd_valid after release.
  - with CNT_W=4, perform 20 writes. Required: wr_count=15.

Source files
------------

// File: rtl/data_mem_responder.sv
//-----------------------------------------------------------------------------
// data_mem_responder
//   Data-memory slave for the single-cycle MIPS core. It answers the core's
//   CEN/WEN/OEN/A/Data2Mem/ReadDataMem strobe interface. Storage is
//   128 x 32-bit words. Writes are synchronous. Reads return through a
//   READ_LAT-deep pipeline.
//
// Parameters
//   READ_LAT : 0 = combinational read of the array; 1 or 2 = registered.
//   CNT_W    : width of the saturating read/write access counters.
//
// Ports
//   clk, rst_n       clock and asynchronous active-low reset
//   CEN, WEN, OEN    active-low chip / write / output enables
//   A, Data2Mem      word address and write data
//   ReadDataMem      read data; holds the last completed read between reads
//   rd_valid         one pulse per completed read
//   err_conflict     sticky: write and read strobed in the same cycle
//   rd_count         completed reads, saturating
//   wr_count         performed writes, saturating
//   dbg_addr         side-band debug address
//   dbg_data         mem[dbg_addr], combinational, side-effect free
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CEN,
  input  logic             WEN,
  input  logic             OEN,
  input  logic [6:0]       A,
  input  logic [31:0]      Data2Mem,
  output logic [31:0]      ReadDataMem,
  output logic             rd_valid,
  output logic             err_conflict,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  input  logic [6:0]       dbg_addr,
  output logic [31:0]      dbg_data
);

  localparam int DEPTH = 128;

  logic             wr_en;
  logic             rd_en;
  logic             conflict;
  logic             rd_done;
  logic [31:0]      rd_word;
  logic [31:0]      mem_q [DEPTH];
  logic             err_q;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;

  // A read is only a read when WEN is high. In a conflict cycle the write
  // therefore wins and the read is dropped.
  assign wr_en    = ~CEN & ~WEN;
  assign rd_en    = ~CEN & ~OEN & WEN;
  assign conflict = ~CEN & ~WEN & ~OEN;

  assign rd_word  = mem_q[A];
  assign dbg_data = mem_q[dbg_addr];

  // The whole array is cleared on reset, so it is built from flops rather
  // than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[A] <= Data2Mem;
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_read
      // Keep a registered copy of the last read. This lets ReadDataMem hold
      // its value between reads without needing a latch.
      logic [31:0] last_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          last_q <= '0;
        end else if (rd_en) begin
          last_q <= rd_word;
        end
      end

      assign ReadDataMem = rd_en ? rd_word : last_q;
      assign rd_valid    = rd_en;
      assign rd_done     = rd_en;
    end else begin : g_pipe_read
      // Stage 0 captures mem[A] on the read edge. The output register is fed
      // from the final stage, so data appears READ_LAT edges after capture.
      // Data is snapshotted at capture, so a later write to the same address
      // cannot disturb a read that is already in flight.
      logic [31:0]         pipe_data_q [READ_LAT];
      logic [READ_LAT-1:0] pipe_vld_q;
      logic [31:0]         out_q;
      logic                vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < READ_LAT; s++) begin
            pipe_data_q[s] <= '0;
          end
          pipe_vld_q <= '0;
          out_q      <= '0;
          vld_q      <= 1'b0;
        end else begin
          pipe_data_q[0] <= rd_word;
          pipe_vld_q[0]  <= rd_en;
          for (int s = 1; s < READ_LAT; s++) begin
            pipe_data_q[s] <= pipe_data_q[s-1];
            pipe_vld_q[s]  <= pipe_vld_q[s-1];
          end
          vld_q <= pipe_vld_q[READ_LAT-1];
          if (pipe_vld_q[READ_LAT-1]) begin
            out_q <= pipe_data_q[READ_LAT-1];
          end
        end
      end

      assign ReadDataMem = out_q;
      assign rd_valid    = vld_q;
      // A read counts as completed on the edge that loads the output register.
      assign rd_done     = pipe_vld_q[READ_LAT-1];
    end
  endgenerate

  // The access counters stick at all-ones instead of wrapping.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_done && !(&rd_cnt_q)) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (wr_en && !(&wr_cnt_q)) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      if (conflict) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;
  assign err_conflict = err_q;

endmodule
